imem_loader: RTL and testbench



---
 rtl/zigma_pkg.sv | 19 +
 rtl/imem_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zigma_pkg.sv
// Shared definitions for the Zigma_RISCV boot loader blocks.
//   loader_state_e : loader FSM state encoding
//   HDR_BYTES      : number of length-header bytes ahead of the payload
//   WORD_W         : instruction word width in bits
package zigma_pkg;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. Receives a byte stream
// {LEN_LO, LEN_HI, LEN x 4-byte little-endian words}, writes each word to the
// instruction memory port and holds the core while loading.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a load (sampled only in IDLE)
//   in_data/in_valid    : input byte stream
//   in_ready            : a byte is accepted when in_valid && in_ready
//   mem_we/addr/wdata   : registered one-cycle memory write
//   cpu_hold, busy      : core stall request / loader not idle
//   done                : one-cycle pulse at end of load
//   err                 : sticky error (length overflow, checksum mismatch)
//   words_loaded        : words written in the current or last load
//
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// checked in a CHECK state after the payload.
//
// ADDR_W is expected to be at most 16 (length header is 16 bits).
module imem_loader
  import zigma_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned ASM_W = WORD_W - 8;
  localparam logic [16:0] DEPTH = 17'(64'd1 << ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e POST_DATA = ST_CHECK;
`else
  localparam loader_state_e POST_DATA = ST_DONE;
`endif

  loader_state_e state_q, state_d;

  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]  word_q, word_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       words_loaded_q, words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] hdr_len;
  logic        len_ovf;
  logic        last_word;

  assign accept    = in_valid && in_ready_q;
  assign hdr_len   = {in_data, len_lo_q};
  assign len_ovf   = {1'b0, hdr_len} > DEPTH;
  // The word being completed is the last one when its index is len-1.
  assign last_word = (words_loaded_q + 16'd1) == len_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LEN0;
      ST_LEN0: if (accept) state_d = ST_LEN1;
      ST_LEN1: begin
        if (accept) begin
          if (len_ovf)                 state_d = ST_IDLE;
          else if (hdr_len == 16'd0)   state_d = POST_DATA;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: if (accept && (byte_cnt_q == 2'd3) && last_word) state_d = POST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: if (accept) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; status outputs follow the next state so
  // they are registered yet aligned with the state they describe.
  always_comb begin
    len_lo_d       = len_lo_q;
    len_d          = len_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    err_d          = err_q;
    words_loaded_d = words_loaded_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d         = csum_q;
`endif
    in_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 (state_d == ST_DATA) || (state_d == ST_CHECK);
    busy_d     = (state_d != ST_IDLE);
    cpu_hold_d = busy_d;
    done_d     = (state_d == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d          = 1'b0;
          words_loaded_d = 16'd0;
          byte_cnt_d     = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = 8'd0;
`endif
        end
      end
      ST_LEN0: if (accept) len_lo_d = in_data;
      ST_LEN1: begin
        if (accept) begin
          len_d = hdr_len;
          if (len_ovf) err_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (accept) begin
          // New byte enters at the top; after four bytes byte 0 sits at [7:0].
          word_d     = {in_data, word_q[ASM_W-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d       = 1'b1;
            mem_addr_d     = ADDR_W'(BASE_ADDR + 32'(words_loaded_q));
            mem_wdata_d    = {in_data, word_q};
            words_loaded_d = words_loaded_q + 16'd1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: if (accept && (in_data != csum_q)) err_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo_q       <= 8'd0;
      len_q          <= 16'd0;
      byte_cnt_q     <= 2'd0;
      word_q         <= '0;
      in_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= 8'd0;
`endif
    end else begin
      len_lo_q       <= len_lo_d;
      len_q          <= len_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      words_loaded_q <= words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=4, BASE_ADDR=0).
// Table of load vectors plus hand-written reset, boundary and checksum cases.
module tb_imem_loader;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   words_loaded;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Event log, sampled on the falling edge.
  int          cyc = 0;
  int          wr_cyc[$];
  logic [AW-1:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cyc[$];
  logic        done_hold, hold_after, busy_after;
  logic [15:0] wl_at_done;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (prev_done) begin
      hold_after = cpu_hold;
      busy_after = busy;
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_hold  = cpu_hold;
      wl_at_done = words_loaded;
    end
    prev_done = done;
  end

  task automatic clear_log();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_cyc.delete();
    done_hold = 1'bx; hold_after = 1'bx; busy_after = 1'bx; wl_at_done = 'x;
  endtask

  logic [7:0] tx_q[$];

  // Called on a falling edge; returns on the falling edge after the last accept.
  task automatic feed(input logic toggle, output int last_acc);
    int   guard;
    logic phase;
    logic acc;
    guard = 0; phase = 1'b1; last_acc = -1;
    while (tx_q.size() != 0 && guard < 2000) begin
      in_valid = toggle ? phase : 1'b1;
      in_data  = tx_q[0];
      acc      = in_valid && in_ready;
      if (acc) last_acc = cyc;
      @(negedge clk);
      if (acc) void'(tx_q.pop_front());
      phase = ~phase;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("feed_bytes_left", tx_q.size(), 0);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_hold_rise"}, cpu_hold, 1);
    chk({tag, "_ready_len0"}, in_ready, 1);
    chk({tag, "_err_cleared"}, err, 0);
    chk({tag, "_wl_cleared"}, words_loaded, 0);
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold_low"}, cpu_hold, 0);
    chk({tag, "_ready_low"}, in_ready, 0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic push_csum(input int first);
    logic [7:0] cs;
    cs = 8'h00;
    for (int j = first; j < tx_q.size(); j++) cs ^= tx_q[j];
    tx_q.push_back(cs);
  endtask
`endif

  typedef struct packed {
    logic [127:0] stream;   // first byte in the top octet
    logic [7:0]   nb;
    logic [1:0]   nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic         toggle;
    logic         exp_err;
    logic         exp_done;
  } vec_t;

  function automatic vec_t mkv(logic [127:0] s, logic [7:0] nb, logic [1:0] nw,
                               logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                               logic tg, logic e, logic d);
    vec_t v;
    v.stream = s; v.nb = nb; v.nw = nw; v.w0 = w0; v.w1 = w1; v.w2 = w2;
    v.toggle = tg; v.exp_err = e; v.exp_done = d;
    return v;
  endfunction

  function automatic logic [31:0] vword(vec_t v, int k);
    if (k == 0) return v.w0;
    if (k == 1) return v.w1;
    return v.w2;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int    last_acc;
    int    nw;
    string t;
    t = $sformatf("v%0d", idx);
    clear_log();
    tx_q.delete();
    for (int j = 0; j < int'(v.nb); j++) tx_q.push_back(v.stream[127-8*j -: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!v.exp_err) push_csum(2);
`endif
    do_start(t);
    feed(v.toggle, last_acc);
    settle(t);
    nw = int'(v.nw);
    chk({t, "_nwrites"}, wr_data.size(), nw);
    for (int k = 0; k < nw && k < wr_data.size(); k++) begin
      chk($sformatf("%s_addr%0d", t, k), 32'(wr_addr[k]), k);
      chk($sformatf("%s_data%0d", t, k), wr_data[k], vword(v, k));
      if (!v.toggle && k > 0) chk($sformatf("%s_gap%0d", t, k), wr_cyc[k] - wr_cyc[k-1], 4);
    end
    chk({t, "_ndone"}, done_cyc.size(), 32'(v.exp_done));
    if (v.exp_done && done_cyc.size() > 0) begin
      chk({t, "_done_time"}, done_cyc[0], last_acc + 1);
      chk({t, "_hold_at_done"}, done_hold, 1);
      chk({t, "_hold_after_done"}, hold_after, 0);
      chk({t, "_busy_after_done"}, busy_after, 0);
      chk({t, "_wl_at_done"}, wl_at_done, nw);
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (nw > 0 && wr_cyc.size() == nw) chk({t, "_last_wr_is_done"}, wr_cyc[nw-1], done_cyc[0]);
`endif
    end
    chk({t, "_err"}, err, 32'(v.exp_err));
    chk({t, "_words_loaded"}, words_loaded, nw);
  endtask

  vec_t vecs[6];
  int   last_acc;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mkv(128'h0200_1300_5000_9300_A000_0000_0000_0000, 8'd10, 2'd2,
                  32'h0050_0013, 32'h00A0_0093, 32'h0, 1'b0, 1'b0, 1'b1);
    vecs[1] = mkv(128'h0000_0000_0000_0000_0000_0000_0000_0000, 8'd2, 2'd0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    vecs[2] = mkv(128'h1100_0000_0000_0000_0000_0000_0000_0000, 8'd2, 2'd0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    vecs[3] = mkv(128'h0100_EFBE_ADDE_0000_0000_0000_0000_0000, 8'd6, 2'd1,
                  32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    vecs[4] = mkv(128'h0001_0000_0000_0000_0000_0000_0000_0000, 8'd2, 2'd0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    vecs[5] = mkv(128'h0300_0102_0304_F0E0_D0C0_7856_3412_0000, 8'd14, 2'd3,
                  32'h0403_0201, 32'hC0D0_E0F0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words_loaded", words_loaded, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // Reset in the middle of a 3-word load (one word plus two bytes in).
    clear_log();
    tx_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start("mid_rst");
    feed(1'b0, last_acc);
    chk("mid_rst_nwrites", wr_data.size(), 1);
    if (wr_data.size() > 0) chk("mid_rst_data0", wr_data[0], 32'h4433_2211);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_wl", words_loaded, 0);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_csum(2);
`endif
    do_start("post_rst");
    feed(1'b0, last_acc);
    settle("post_rst");
    chk("post_rst_nwrites", wr_data.size(), 1);
    if (wr_data.size() > 0) begin
      chk("post_rst_addr", 32'(wr_addr[0]), 0);
      chk("post_rst_data", wr_data[0], 32'hDDCC_BBAA);
    end
    chk("post_rst_wl", words_loaded, 1);

    // Largest accepted length: fills every address of a 16-word memory.
    clear_log();
    tx_q = '{8'h10, 8'h00};
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(i));
      tx_q.push_back(8'h5A);
      tx_q.push_back(8'hFF ^ 8'(i));
      tx_q.push_back(8'h80);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_csum(2);
`endif
    do_start("full");
    feed(1'b0, last_acc);
    settle("full");
    chk("full_nwrites", wr_data.size(), 16);
    for (int i = 0; i < 16 && i < wr_data.size(); i++) begin
      chk($sformatf("full_addr%0d", i), 32'(wr_addr[i]), i);
      chk($sformatf("full_data%0d", i), wr_data[i], {8'h80, 8'hFF ^ 8'(i), 8'h5A, 8'(i)});
    end
    chk("full_err", err, 0);
    chk("full_wl", words_loaded, 16);
    chk("full_ndone", done_cyc.size(), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum byte wrong: error flagged, load still completes.
    clear_log();
    tx_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    do_start("cs_bad");
    feed(1'b0, last_acc);
    settle("cs_bad");
    chk("cs_bad_err", err, 1);
    chk("cs_bad_ndone", done_cyc.size(), 1);
    chk("cs_bad_nwrites", wr_data.size(), 1);
    // Checksum byte right.
    clear_log();
    tx_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    do_start("cs_good");
    feed(1'b0, last_acc);
    settle("cs_good");
    chk("cs_good_err", err, 0);
    chk("cs_good_ndone", done_cyc.size(), 1);
    if (wr_data.size() > 0) chk("cs_good_data", wr_data[0], 32'h0000_0013);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
